countdown_timer: RTL and testbench

- Loadable down-counting sequencer. It is the complement of the team's 4-bit up-counter, which computes the next state from externally held state bits.
- This block owns its state register. It decrements from a loaded value to zero, signals terminal count, and can auto-reload.
- It sits beside the up-counter and provides timed intervals: debounce, display refresh and test-sequence pacing.
- It has a three-state control FSM: IDLE, RUN and DONE.

---
 rtl/countdown_timer_if.sv | 22 ++
 rtl/countdown_timer.sv | 91 +++++++++
 tb/tb_countdown_timer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the master drives the control
// inputs, the slave (the timer) returns its registered count and status.
interface countdown_timer_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             reload_en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, enable, reload_en, abort,
    input  count, busy, done
  );

  modport slave (
    input  start, load_val, enable, reload_en, abort,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// Owns its count register; three-state control FSM (IDLE, RUN, DONE).
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  countdown_timer_if.slave    bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] cap_r;
  logic             busy_r;
  logic             done_r;

  assign bus.count = count_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign state_dbg = state;

  // Handshake: start is a request taken only in IDLE; busy high means the
  // request is not ready and start is dropped without any effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count_r <= '0;
      cap_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (bus.abort && (state != IDLE)) begin
      state   <= IDLE;
      count_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cap_r  <= bus.load_val;
            busy_r <= 1'b1;
            if (bus.load_val != '0) begin
              count_r <= bus.load_val;
              state   <= RUN;
              done_r  <= 1'b0;
            end else begin
              // Zero-length interval: straight to the terminal-count cycle.
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.enable && (count_r != '0)) begin
            count_r <= count_r - WIDTH'(1);
            if (count_r == WIDTH'(1)) begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        DONE: begin
          done_r <= 1'b0;
          if (bus.reload_en && (cap_r != '0)) begin
            count_r <= cap_r;
            state   <= RUN;
            busy_r  <= 1'b1;
          end else begin
            count_r <= '0;
            state   <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          count_r <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios followed by randomized runs
// whose expected per-cycle trace is derived from tick counting.
module tb_countdown_timer;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic             s;
    logic [WIDTH-1:0] lv;
    logic             en;
    logic             rl;
    logic             ab;
  } stim_t;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         total;
  int         bad;

  stim_t                stim_q[$];
  logic [WIDTH+1:0]     exp_q[$];

  countdown_timer_if #(.WIDTH(WIDTH)) bus ();

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [WIDTH+1:0] obs,
                     input logic [WIDTH+1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed busy/done/count=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input stim_t st);
    bus.start     = st.s;
    bus.load_val  = st.lv;
    bus.enable    = st.en;
    bus.reload_en = st.rl;
    bus.abort     = st.ab;
  endtask

  // One clock step: apply inputs, take the edge, check outputs 1 time unit later.
  task automatic cyc(input logic s, input logic [WIDTH-1:0] lv, input logic en,
                     input logic rl, input logic ab, input string tag,
                     input logic [WIDTH-1:0] c, input logic b, input logic d);
    drive('{s: s, lv: lv, en: en, rl: rl, ab: ab});
    @(posedge clk);
    #1;
    chk(tag, {bus.busy, bus.done, bus.count}, {b, d, c});
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [WIDTH-1:0] rval();
    return WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
  endfunction

  // Builds the expected trace from the counting rules: after start the count
  // equals L minus the number of enabled ticks seen, done marks the tick where
  // that reaches zero, and the following cycle either reloads or idles.
  task automatic gen_runs(input int n_runs);
    for (int r = 0; r < n_runs; r++) begin
      int  L;
      int  reloads;
      int  ticks;
      bit  aborted;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        stim_q.push_back('{s: 1'b0, lv: rval(), en: rbit(), rl: rbit(), ab: rbit()});
        exp_q.push_back('0);
      end
      L       = (r % 8 == 3) ? 0 : (r % 8 == 5) ? 15 : int'($urandom_range(0, 15));
      reloads = int'($urandom_range(0, 2));
      stim_q.push_back('{s: 1'b1, lv: WIDTH'(L), en: rbit(), rl: rbit(), ab: rbit()});
      exp_q.push_back((L == 0) ? {1'b1, 1'b1, WIDTH'(0)} : {1'b1, 1'b0, WIDTH'(L)});
      if (L == 0) begin
        stim_q.push_back('{s: rbit(), lv: rval(), en: rbit(), rl: rbit(), ab: 1'b0});
        exp_q.push_back('0);
        continue;
      end
      aborted = 0;
      forever begin
        ticks = 0;
        while (ticks < L) begin
          logic en;
          if ($urandom_range(0, 39) == 0) begin
            stim_q.push_back('{s: rbit(), lv: rval(), en: rbit(), rl: rbit(), ab: 1'b1});
            exp_q.push_back('0);
            aborted = 1;
            break;
          end
          en = ($urandom_range(0, 3) != 0);
          ticks += int'(en);
          stim_q.push_back('{s: rbit(), lv: rval(), en: en, rl: rbit(), ab: 1'b0});
          exp_q.push_back({1'b1, (ticks == L), WIDTH'(L - ticks)});
        end
        if (aborted) break;
        if (reloads > 0) begin
          stim_q.push_back('{s: rbit(), lv: rval(), en: rbit(), rl: 1'b1, ab: 1'b0});
          exp_q.push_back({1'b1, 1'b0, WIDTH'(L)});
          reloads--;
        end else begin
          stim_q.push_back('{s: rbit(), lv: rval(), en: rbit(), rl: 1'b0, ab: 1'b0});
          exp_q.push_back('0);
          break;
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive('{s: 1'b0, lv: '0, en: 1'b0, rl: 1'b0, ab: 1'b0});
    #2;
    chk("reset_state", {bus.busy, bus.done, bus.count}, '0);
    total++;
    assert (state_dbg === 2'd0) else begin
      bad++;
      $error("FAIL reset_fsm: observed=%0d expected=0", state_dbg);
    end
    #1 reset = 1'b0;

    // basic: load 5, enable held
    cyc(1, 5, 1, 0, 0, "basic_start", 5, 1, 0);
    for (int i = 4; i >= 0; i--)
      cyc(0, 0, 1, 0, 0, $sformatf("basic_dec%0d", i), WIDTH'(i), 1, (i == 0));
    cyc(0, 0, 1, 0, 0, "basic_idle", 0, 0, 0);

    // gated ticks
    cyc(1, 3, 0, 0, 0, "gate_start", 3, 1, 0);
    cyc(0, 0, 1, 0, 0, "gate_t1", 2, 1, 0);
    cyc(0, 0, 0, 0, 0, "gate_h1", 2, 1, 0);
    cyc(0, 0, 1, 0, 0, "gate_t2", 1, 1, 0);
    cyc(0, 0, 0, 0, 0, "gate_h2", 1, 1, 0);
    cyc(0, 0, 1, 0, 0, "gate_t3", 0, 1, 1);
    cyc(0, 0, 0, 0, 0, "gate_idle", 0, 0, 0);

    // auto-reload, then drop reload_en
    cyc(1, 2, 1, 1, 0, "rld_start", 2, 1, 0);
    cyc(0, 0, 1, 1, 0, "rld_a1", 1, 1, 0);
    cyc(0, 0, 1, 1, 0, "rld_a0", 0, 1, 1);
    cyc(0, 0, 1, 1, 0, "rld_reload", 2, 1, 0);
    cyc(0, 0, 1, 1, 0, "rld_b1", 1, 1, 0);
    cyc(0, 0, 1, 0, 0, "rld_b0", 0, 1, 1);
    cyc(0, 0, 1, 0, 0, "rld_end", 0, 0, 0);

    // zero load never reloads
    cyc(1, 0, 1, 1, 0, "zero_done", 0, 1, 1);
    cyc(0, 0, 1, 1, 0, "zero_idle", 0, 0, 0);
    cyc(0, 0, 1, 1, 0, "zero_stay", 0, 0, 0);

    // full-scale load, no wrap
    cyc(1, 15, 1, 0, 0, "max_start", 15, 1, 0);
    for (int i = 14; i >= 0; i--)
      cyc(0, 0, 1, 0, 0, $sformatf("max_dec%0d", i), WIDTH'(i), 1, (i == 0));
    cyc(0, 0, 1, 0, 0, "max_idle", 0, 0, 0);

    // abort mid-run at count 4
    cyc(1, 9, 1, 0, 0, "abt_start", 9, 1, 0);
    for (int i = 8; i >= 4; i--)
      cyc(0, 0, 1, 0, 0, $sformatf("abt_dec%0d", i), WIDTH'(i), 1, 0);
    cyc(0, 0, 1, 0, 1, "abt_hit", 0, 0, 0);
    cyc(0, 0, 1, 0, 0, "abt_idle", 0, 0, 0);

    // abort sampled in DONE still shows done that cycle, wins over reload
    cyc(1, 1, 1, 1, 0, "abtd_start", 1, 1, 0);
    cyc(0, 0, 1, 1, 0, "abtd_done", 0, 1, 1);
    cyc(0, 0, 1, 1, 1, "abtd_hit", 0, 0, 0);

    // stray start while running
    cyc(1, 5, 0, 0, 0, "stray_start", 5, 1, 0);
    cyc(1, 7, 0, 0, 0, "stray_hold", 5, 1, 0);
    cyc(1, 7, 1, 0, 0, "stray_dec", 4, 1, 0);
    for (int i = 3; i >= 0; i--)
      cyc(0, 0, 1, 0, 0, $sformatf("stray_dec%0d", i), WIDTH'(i), 1, (i == 0));
    cyc(0, 0, 1, 0, 0, "stray_idle", 0, 0, 0);

    // start beats abort in IDLE
    cyc(1, 3, 0, 0, 1, "sa_start", 3, 1, 0);
    cyc(0, 0, 0, 0, 1, "sa_abort", 0, 0, 0);

    // asynchronous reset between edges
    cyc(1, 9, 1, 0, 0, "ar_start", 9, 1, 0);
    for (int i = 8; i >= 6; i--)
      cyc(0, 0, 1, 0, 0, $sformatf("ar_dec%0d", i), WIDTH'(i), 1, 0);
    #2 reset = 1'b1;
    #1 chk("async_reset", {bus.busy, bus.done, bus.count}, '0);
    #2 reset = 1'b0;
    cyc(1, 4, 1, 0, 0, "ar_restart", 4, 1, 0);
    for (int i = 3; i >= 0; i--)
      cyc(0, 0, 1, 0, 0, $sformatf("ar_dec%0d", i), WIDTH'(i), 1, (i == 0));
    cyc(0, 0, 1, 0, 0, "ar_idle", 0, 0, 0);

    // randomized runs against the expected-trace scoreboard
    gen_runs(40);
    for (int n = 0; stim_q.size() > 0; n++) begin
      stim_t            st;
      logic [WIDTH+1:0] exp;
      st  = stim_q.pop_front();
      exp = exp_q.pop_front();
      drive(st);
      @(posedge clk);
      #1;
      chk($sformatf("rand_cyc%0d", n), {bus.busy, bus.done, bus.count}, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
